// File: rtl/image_pack64.sv
// Packs the two-pixel-per-cycle RGB888 stream into 64-bit words with line-end tagging,
// line counting and a valid/ready FIFO output. Define PACK_RGB_ORDER_EN for R,G,B byte order.
module image_pack64 #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned DEPTH  = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [9:0]  line_cnt,
  output logic        overflow,
  output logic        frame_done
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  if ((WIDTH % 2) != 0 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || HEIGHT > 1023) begin : g_param_check
    $error("image_pack64: illegal WIDTH/HEIGHT/DEPTH setting");
  end

  logic [111:0]  acc;
  logic [3:0]    resid;
  logic          in_burst;
  logic          tail_open;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [63:0]   mem [DEPTH];
  logic [DEPTH-1:0] last_mem;

  logic [47:0]   pix_bytes;
  logic [111:0]  merged;
  logic [111:0]  acc_nxt;
  logic [3:0]    resid_nxt;
  logic [63:0]   push_data;
  logic          push;
  logic          push_last;
  logic          hs_act;
  logic          burst_end;
  logic          full;
  logic          empty;
  logic          pop;
  logic          accept;
  logic          patch;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          tail_is_head;

`ifdef PACK_RGB_ORDER_EN
  assign pix_bytes = {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0};
`else
  assign pix_bytes = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
`endif

  assign merged = acc | ({64'b0, pix_bytes} << {resid, 3'b000});

  always_comb begin
    hs_act    = HSYNC && !VSYNC;
    burst_end = in_burst && !HSYNC && !VSYNC;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    acc_nxt   = acc;
    resid_nxt = resid;
    if (hs_act) begin
      if (resid >= 4'd2) begin
        push      = 1'b1;
        push_data = merged[63:0];
        acc_nxt   = {64'b0, merged[111:64]};
        resid_nxt = resid - 4'd2;
      end else begin
        acc_nxt   = merged;
        resid_nxt = resid + 4'd6;
      end
    end else if (burst_end && resid != 4'd0) begin
      push      = 1'b1;
      push_last = 1'b1;
      push_data = acc[63:0];
      acc_nxt   = '0;
      resid_nxt = '0;
    end
  end

  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign m_valid      = !empty;
  assign pop          = m_valid && m_ready;
  assign accept       = push && (!full || pop);
  assign head_idx     = rptr[AW-1:0];
  assign tail_idx     = wptr[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
  assign tail_is_head = ((wptr - PTR_ONE) == rptr);

  // A word that empties the accumulator is only known to end the line once HSYNC
  // drops the next cycle; its stored tag is patched then, and bypassed if it is at the head.
  assign patch      = burst_end && tail_open;
  assign m_data     = m_valid ? mem[head_idx] : '0;
  assign m_last     = m_valid && (last_mem[head_idx] || (patch && tail_is_head));
  assign frame_done = (line_cnt == HEIGHT_L) && empty;

  always_ff @(posedge HCLK) begin
    if (accept) begin
      mem[wptr[AW-1:0]]      <= push_data;
      last_mem[wptr[AW-1:0]] <= push_last;
    end
    if (patch) begin
      last_mem[tail_idx] <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc       <= '0;
      resid     <= '0;
      in_burst  <= 1'b0;
      tail_open <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      line_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (VSYNC) begin
      acc       <= '0;
      resid     <= '0;
      in_burst  <= 1'b0;
      tail_open <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      line_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      resid     <= resid_nxt;
      in_burst  <= HSYNC;
      tail_open <= hs_act && accept && (resid_nxt == 4'd0);
      if (accept) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      if (burst_end && line_cnt != HEIGHT_L) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_pack64.sv
// Scoreboard bench for image_pack64: a byte-stream model predicts every output word,
// a monitor pops and compares whenever a word is handed off.
module tb_image_pack64;

  localparam int unsigned WIDTH  = 768;
  localparam int unsigned HEIGHT = 4;
  localparam int unsigned DEPTH  = 64;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        VSYNC   = 1'b0;
  logic        HSYNC   = 1'b0;
  logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
  logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
  logic [63:0] m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [9:0]  line_cnt;
  logic        overflow;
  logic        frame_done;

  image_pack64 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .line_cnt(line_cnt), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [7:0] r0, g0, b0, r1, g1, b1;
  } pix_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t        sbq[$];
  pix_t        line_px[$];
  int unsigned n_checks   = 0;
  int unsigned n_fail     = 0;
  int unsigned words_seen = 0;
  int unsigned lasts_seen = 0;
  bit          rnd_ready  = 1'b0;
  logic        hold_pend  = 1'b0;
  logic [63:0] hold_d     = '0;
  logic        hold_l     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    if (rnd_ready) m_ready = ($urandom_range(3) != 0);
  endtask

  task automatic make_line(input int unsigned n, input bit rnd);
    pix_t p;
    line_px.delete();
    for (int unsigned i = 0; i < n; i++) begin
      if (rnd) begin
        p.r0 = 8'($urandom); p.g0 = 8'($urandom); p.b0 = 8'($urandom);
        p.r1 = 8'($urandom); p.g1 = 8'($urandom); p.b1 = 8'($urandom);
      end else begin
        p.r0 = 8'h01; p.g0 = 8'h02; p.b0 = 8'h03;
        p.r1 = 8'h04; p.g1 = 8'h05; p.b1 = 8'h06;
      end
      line_px.push_back(p);
    end
  endtask

  // Reference: flatten the line to its byte stream, cut into 8-byte words, pad the tail.
  task automatic expect_line(input int unsigned max_keep);
    logic [7:0]  q[$];
    int unsigned nw;
    foreach (line_px[i]) begin
`ifdef PACK_RGB_ORDER_EN
      q.push_back(line_px[i].r0); q.push_back(line_px[i].g0); q.push_back(line_px[i].b0);
      q.push_back(line_px[i].r1); q.push_back(line_px[i].g1); q.push_back(line_px[i].b1);
`else
      q.push_back(line_px[i].b0); q.push_back(line_px[i].g0); q.push_back(line_px[i].r0);
      q.push_back(line_px[i].b1); q.push_back(line_px[i].g1); q.push_back(line_px[i].r1);
`endif
    end
    nw = (q.size() + 7) / 8;
    for (int unsigned w = 0; w < nw; w++) begin
      exp_t e;
      e.d = '0;
      for (int unsigned k = 0; k < 8; k++) begin
        if (8 * w + k < q.size()) e.d[8*k +: 8] = q[8*w+k];
      end
      e.l = (w == nw - 1);
      if (w < max_keep) sbq.push_back(e);
    end
  endtask

  task automatic set_pix(input pix_t p);
    DATA_R0 = p.r0; DATA_G0 = p.g0; DATA_B0 = p.b0;
    DATA_R1 = p.r1; DATA_G1 = p.g1; DATA_B1 = p.b1;
  endtask

  task automatic drive_line(input int ready_on, input bit chk_lat);
    for (int i = 0; i < line_px.size(); i++) begin
      tick();
      HSYNC = 1'b1;
      set_pix(line_px[i]);
      if (i == ready_on) m_ready = 1'b1;
      if (chk_lat && i < 3) begin
        @(negedge HCLK);
        check($sformatf("valid_latency_c%0d", i), {63'b0, m_valid}, {63'b0, (i == 2)});
      end
    end
    tick();
    HSYNC = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned maxc);
    for (int unsigned i = 0; i < maxc && (sbq.size() != 0 || m_valid); i++) tick();
    tick();
    tick();
    check("drain_sb_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic vsync_pulse();
    tick();
    VSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    tick();
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && hold_pend && m_valid) begin
        check("hold_data", m_data, hold_d);
        check("hold_last", {63'b0, m_last}, {63'b0, hold_l});
      end
      if (HRESETn && m_valid && m_ready) begin
        words_seen++;
        if (m_last) lasts_seen++;
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got word %h last %0b, expected no word", m_data, m_last);
        end else begin
          e = sbq.pop_front();
          check("word_data", m_data, e.d);
          check("word_last", {63'b0, m_last}, {63'b0, e.l});
        end
      end
      hold_pend = HRESETn && !VSYNC && m_valid && !m_ready;
      hold_d    = m_data;
      hold_l    = m_last;
    end
  endtask

  initial begin
    int unsigned w0, l0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_m_valid", {63'b0, m_valid}, 64'd0);
    check("rst_m_last", {63'b0, m_last}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_line_cnt", {54'b0, line_cnt}, 64'd0);
    check("rst_overflow", {63'b0, overflow}, 64'd0);
    check("rst_frame_done", {63'b0, frame_done}, 64'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    m_ready = 1'b1;

    // Fixed-pattern ordering, latency, last-word marking without flush
    make_line(4, 1'b0);
    expect_line(1000);
    drive_line(-1, 1'b1);
    wait_drain(200);
    check("basic_line_cnt", {54'b0, line_cnt}, 64'd1);

    // Single-cycle burst forces a padded flush word
    make_line(1, 1'b0);
    expect_line(1000);
    drive_line(-1, 1'b0);
    wait_drain(200);
    check("flush_line_cnt", {54'b0, line_cnt}, 64'd2);

    // Random short bursts under random backpressure; line_cnt saturates at HEIGHT
    rnd_ready = 1'b1;
    repeat (5) begin
      make_line($urandom_range(40, 1), 1'b1);
      expect_line(1000);
      drive_line(-1, 1'b0);
      wait_drain(400);
    end
    rnd_ready = 1'b0;
    m_ready   = 1'b1;
    check("sat_line_cnt", {54'b0, line_cnt}, 64'(HEIGHT));
    check("sat_frame_done", {63'b0, frame_done}, 64'd1);
    check("rand_overflow", {63'b0, overflow}, 64'd0);
    vsync_pulse();
    check("vsync_line_cnt", {54'b0, line_cnt}, 64'd0);
    check("vsync_frame_done", {63'b0, frame_done}, 64'd0);

    // Full frame
    w0 = words_seen;
    l0 = lasts_seen;
    repeat (HEIGHT) begin
      make_line(WIDTH / 2, 1'b1);
      expect_line(1000);
      drive_line(-1, 1'b0);
      repeat (160) tick();
    end
    wait_drain(400);
    check("frame_words", 64'(words_seen - w0), 64'(HEIGHT * WIDTH * 3 / 8));
    check("frame_lasts", 64'(lasts_seen - l0), 64'(HEIGHT));
    check("frame_line_cnt", {54'b0, line_cnt}, 64'(HEIGHT));
    check("frame_done_set", {63'b0, frame_done}, 64'd1);
    check("frame_overflow", {63'b0, overflow}, 64'd0);
    vsync_pulse();
    check("clr_line_cnt", {54'b0, line_cnt}, 64'd0);
    check("clr_frame_done", {63'b0, frame_done}, 64'd0);

    // Backpressure through a whole line: only the first DEPTH words survive
    m_ready = 1'b0;
    make_line(WIDTH / 2, 1'b1);
    expect_line(DEPTH);
    drive_line(-1, 1'b0);
    repeat (3) tick();
    check("bp_overflow", {63'b0, overflow}, 64'd1);
    check("bp_m_valid", {63'b0, m_valid}, 64'd1);
    check("bp_line_cnt", {54'b0, line_cnt}, 64'd1);
    w0 = words_seen;
    m_ready = 1'b1;
    wait_drain(400);
    check("bp_drained", 64'(words_seen - w0), 64'(DEPTH));
    check("bp_empty", {63'b0, m_valid}, 64'd0);
    vsync_pulse();
    check("bp_ovf_clear", {63'b0, overflow}, 64'd0);

    // Fill to exactly DEPTH (86 cycles), then pop while still pushing into a full FIFO
    m_ready = 1'b0;
    make_line(88, 1'b1);
    expect_line(1000);
    drive_line(86, 1'b0);
    wait_drain(400);
    check("fullpp_overflow", {63'b0, overflow}, 64'd0);

    // Reset mid-line: partial data discarded, no flush afterwards
    m_ready = 1'b0;
    make_line(10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      HSYNC = 1'b1;
      set_pix(line_px[i]);
    end
    tick();
    HRESETn = 1'b0;
    HSYNC   = 1'b0;
    #1;
    check("mid_rst_m_valid", {63'b0, m_valid}, 64'd0);
    check("mid_rst_m_last", {63'b0, m_last}, 64'd0);
    check("mid_rst_m_data", m_data, 64'd0);
    check("mid_rst_line_cnt", {54'b0, line_cnt}, 64'd0);
    check("mid_rst_overflow", {63'b0, overflow}, 64'd0);
    check("mid_rst_frame_done", {63'b0, frame_done}, 64'd0);
    tick();
    tick();
    HRESETn = 1'b1;
    m_ready = 1'b1;
    repeat (10) tick();
    check("post_rst_no_flush", {63'b0, m_valid}, 64'd0);
    check("post_rst_line_cnt", {54'b0, line_cnt}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
